// File: rtl/rgn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgn_pkg
// Purpose  : Shared definitions for the rgn_mode register: operation-select
//            width and the encodings of the eight operations.
// Revision : 1.0  initial release
// ============================================================================
package rgn_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_HOLD = 3'b000;
    localparam op_t OP_LOAD = 3'b001;
    localparam op_t OP_INC  = 3'b010;
    localparam op_t OP_DEC  = 3'b011;
    localparam op_t OP_ASL  = 3'b100;
    localparam op_t OP_LSR  = 3'b101;
    localparam op_t OP_ROL  = 3'b110;
    localparam op_t OP_ROR  = 3'b111;

endpackage : rgn_pkg
`default_nettype wire

// File: rtl/rgn_shift.sv
`default_nettype none
// ============================================================================
// Module   : rgn_shift
// Purpose  : Combinational shift/rotate next-value and carry generation for
//            rgn_mode (ASL, LSR, ROL, ROR).
// Ports    : din   - current register contents
//            ci    - carry-in shifted into the vacated bit on rotates
//            op    - operation select (only shift ops produce a new value;
//                    any other code passes din/co_in through)
//            co_in - current carry flag, returned for non-shift codes
//            dout  - next register value
//            co    - next carry flag (bit shifted out)
// Revision : 1.0  initial release
// ============================================================================
module rgn_shift
    import rgn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic             ci,
    input  logic [OP_W-1:0]  op,
    input  logic             co_in,
    output logic [WIDTH-1:0] dout,
    output logic             co
);

    always_comb begin
        dout = din;
        co   = co_in;
        case (op)
            OP_ASL: begin
                dout = {din[WIDTH-2:0], 1'b0};
                co   = din[WIDTH-1];
            end
            OP_LSR: begin
                dout = {1'b0, din[WIDTH-1:1]};
                co   = din[0];
            end
            OP_ROL: begin
                dout = {din[WIDTH-2:0], ci};
                co   = din[WIDTH-1];
            end
            OP_ROR: begin
                dout = {ci, din[WIDTH-1:1]};
                co   = din[0];
            end
            default: begin
                dout = din;
                co   = co_in;
            end
        endcase
    end

endmodule : rgn_shift
`default_nettype wire

// File: rtl/rgn_mode.sv
`default_nettype none
// ============================================================================
// Module   : rgn_mode
// Purpose  : Single WIDTH-bit register with load/inc/dec and (optionally)
//            shift/rotate operations, a registered carry/borrow flag and
//            combinational zero/negative flags.
// Config   : RGN_MODE_SHIFT_EN - when defined, ops 100..111 perform
//            ASL/LSR/ROL/ROR via rgn_shift; when undefined they hold and
//            ci is unused.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset (dout=RST_VAL, co=0)
//            di   - parallel load data
//            ci   - carry-in for rotates
//            op   - operation select (rgn_pkg encodings)
//            dout - register contents ('do' is a reserved word)
//            co   - registered carry/borrow flag
//            zo   - high when dout == 0
//            no   - dout MSB
// Revision : 1.0  initial release
// ============================================================================
module rgn_mode
    import rgn_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] di,
    input  logic             ci,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] dout,
    output logic             co,
    output logic             zo,
    output logic             no
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_do;
    logic             r_co;
    logic [WIDTH-1:0] w_nxt_do;
    logic             w_nxt_co;
    logic [WIDTH-1:0] w_sh_do;
    logic             w_sh_co;

`ifdef RGN_MODE_SHIFT_EN
    rgn_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .din   (r_do),
        .ci    (ci),
        .op    (op),
        .co_in (r_co),
        .dout  (w_sh_do),
        .co    (w_sh_co)
    );
`else
    // Shift ops collapse to hold; ci has no consumer in this build.
    logic w_unused_ci;
    assign w_unused_ci = ci;
    assign w_sh_do     = r_do;
    assign w_sh_co     = r_co;
`endif

    always_comb begin
        w_nxt_do = r_do;
        w_nxt_co = r_co;
        case (op)
            OP_HOLD: begin
                w_nxt_do = r_do;
                w_nxt_co = r_co;
            end
            OP_LOAD: begin
                w_nxt_do = di;
            end
            OP_INC: begin
                w_nxt_do = r_do + c_one;
                // Carry only on the all-ones -> zero wrap.
                w_nxt_co = &r_do;
            end
            OP_DEC: begin
                w_nxt_do = r_do - c_one;
                // Borrow convention: flag drops to 0 only on zero -> all-ones.
                w_nxt_co = |r_do;
            end
            default: begin
                w_nxt_do = w_sh_do;
                w_nxt_co = w_sh_co;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_do <= RST_VAL;
            r_co <= 1'b0;
        end else begin
            r_do <= w_nxt_do;
            r_co <= w_nxt_co;
        end
    end

    assign dout = r_do;
    assign co   = r_co;
    assign zo   = (r_do == '0);
    assign no   = r_do[WIDTH-1];

endmodule : rgn_mode
`default_nettype wire

// File: tb/tb_rgn_mode.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgn_mode
// Purpose  : Directed, table-driven self-checking bench for rgn_mode
//            (WIDTH=8, RST_VAL=8'h5A), plus hand-written reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_rgn_mode;
    import rgn_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] di;
    logic         ci;
    logic [OP_W-1:0] op;
    logic [W-1:0] dout;
    logic         co;
    logic         zo;
    logic         no;

    always #5 clk = ~clk;

    rgn_mode #(
        .WIDTH   (W),
        .RST_VAL (8'h5A)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .di   (di),
        .ci   (ci),
        .op   (op),
        .dout (dout),
        .co   (co),
        .zo   (zo),
        .no   (no)
    );

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] di;
        logic         ci;
        logic [W-1:0] e_do;
        logic         e_co;
        logic         e_zo;
        logic         e_no;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t mk(input string nm, input logic [2:0] o,
                                input logic [W-1:0] d, input logic c,
                                input logic [W-1:0] edo, input logic eco,
                                input logic ezo, input logic eno);
        vec_t v;
        v.name = nm; v.op = o; v.di = d; v.ci = c;
        v.e_do = edo; v.e_co = eco; v.e_zo = ezo; v.e_no = eno;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [W-1:0] e_do,
                           input logic e_co, input logic e_zo, input logic e_no);
        chk({nm, ".do"}, dout, e_do);
        chk({nm, ".co"}, {7'd0, co}, {7'd0, e_co});
        chk({nm, ".zo"}, {7'd0, zo}, {7'd0, e_zo});
        chk({nm, ".no"}, {7'd0, no}, {7'd0, e_no});
    endtask

    task automatic step(input logic [2:0] o, input logic [W-1:0] d, input logic c);
        @(negedge clk);
        op = o; di = d; ci = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset value starts at 5A; every step below is hand-computed.
        vecs.push_back(mk("load80",  OP_LOAD, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("hold1",   OP_HOLD, 8'h11, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("hold2",   OP_HOLD, 8'h22, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("hold3",   OP_HOLD, 8'h33, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("loadFF",  OP_LOAD, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("incwrap", OP_INC,  8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("inc01",   OP_INC,  8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("load00",  OP_LOAD, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0));
        vecs.push_back(mk("decwrap", OP_DEC,  8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("decFE",   OP_DEC,  8'h00, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("holdFE",  OP_HOLD, 8'h00, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("loadco1", OP_LOAD, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("holdco1", OP_HOLD, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("inc81",   OP_INC,  8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("dec80",   OP_DEC,  8'h00, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("load81",  OP_LOAD, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1));
`ifdef RGN_MODE_SHIFT_EN
        vecs.push_back(mk("asl",     OP_ASL,  8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("lsr1",    OP_LSR,  8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk("lsr0",    OP_LSR,  8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk("reload81",OP_LOAD, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("rol_ci0", OP_ROL,  8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("ror_ci1", OP_ROR,  8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk("rol_ci1", OP_ROL,  8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk("ror_ci0", OP_ROR,  8'h00, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0));
`else
        vecs.push_back(mk("off_asl", OP_ASL,  8'h00, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("off_lsr", OP_LSR,  8'h3C, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("off_rol", OP_ROL,  8'h00, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk("off_ror", OP_ROR,  8'hFF, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1));
`endif

        // Reset asserted at time 0, before any clock edge.
        rst = 1'b1; op = OP_INC; di = 8'h00; ci = 1'b0;
        #2;
        chk_all("reset", 8'h5A, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        rst = 1'b0; op = OP_HOLD;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].op, vecs[i].di, vecs[i].ci);
            chk_all(vecs[i].name, vecs[i].e_do, vecs[i].e_co,
                    vecs[i].e_zo, vecs[i].e_no);
        end

        // co is 1 here; async reset mid-inc must act before the next edge.
        @(negedge clk);
        op = OP_INC;
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_midinc", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Inputs ignored while reset is held across an edge.
        @(negedge clk);
        op = OP_LOAD; di = 8'h00;
        @(posedge clk);
        #1;
        chk_all("rst_hold", 8'h5A, 1'b0, 1'b0, 1'b0);

        // First op after release operates on RST_VAL.
        @(negedge clk);
        rst = 1'b0; op = OP_INC;
        @(posedge clk);
        #1;
        chk_all("post_rst_inc", 8'h5B, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_rgn_mode
`default_nettype wire

// File: doc/rgn_mode.md
RGN_MODE -- requirements
Module: rgn_mode

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (min 2).
REQ-002 SHALL have parameter RST_VAL, default 0, value loaded into do on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port di  input  WIDTH  parallel data input.
REQ-006 SHALL have port ci  input  1  carry-in for rotate operations.
REQ-007 SHALL have port op  input  3  operation select, sampled every rising edge.
REQ-008 SHALL have port do  output  WIDTH  register contents.
REQ-009 SHALL have port co  output  1  registered carry/borrow flag.
REQ-010 SHALL have port zo  output  1  combinational zero flag, high when do == 0.
REQ-011 SHALL have port no  output  1  combinational negative flag, equal to do[WIDTH-1].

Function
REQ-012 SHALL decode op: 000 hold, 001 load, 010 inc, 011 dec, 100 asl, 101 lsr, 110 rol, 111 ror.
REQ-013 SHALL, on hold, keep do and co unchanged.
REQ-014 SHALL, on load, set do <= di; co unchanged.
REQ-015 SHALL, on inc, set do <= do+1 modulo 2^WIDTH; co <= 1 only when do was all-ones (wrap to 0), else 0.
REQ-016 SHALL, on dec, set do <= do-1 modulo 2^WIDTH; co <= 0 only when do was 0 (wrap to all-ones, borrow), else 1.
REQ-017 SHALL, on asl, set do <= {do[WIDTH-2:0],0}; co <= old do[WIDTH-1].
REQ-018 SHALL, on lsr, set do <= {0,do[WIDTH-1:1]}; co <= old do[0].
REQ-019 SHALL, on rol, set do <= {do[WIDTH-2:0],ci}; co <= old do[WIDTH-1].
REQ-020 SHALL, on ror, set do <= {ci,do[WIDTH-1:1]}; co <= old do[0].
REQ-021 SHALL take effect with exactly one cycle latency: result visible on do/co after the edge that sampled op.
REQ-022 SHALL update zo/no in the same cycle do changes, with no extra register stage.
REQ-023 SHALL treat op, di, ci as don't-care while rst is high.

Reset
REQ-024 SHALL, while rst is high, force do = RST_VAL and co = 0 immediately, independent of clk.
REQ-025 SHALL, on rst asserted mid-operation, discard any in-flight op; first op after deassertion uses RST_VAL as operand.
REQ-026 SHALL resume normal operation on the first rising clk edge after rst falls.

Configuration
REQ-027 SHALL honour macro RGN_MODE_SHIFT_EN: when defined, ops 100-111 behave per REQ-017..020.
REQ-028 SHALL, when RGN_MODE_SHIFT_EN is undefined, treat ops 100-111 as hold and omit shifter logic; ci then unused.

Structure
REQ-029 SHALL take op encodings (OP_HOLD..OP_ROR) and op width from shared package rgn_pkg.
REQ-030 SHALL place shift/rotate next-value and carry logic in sub-module rgn_shift, instantiated only under RGN_MODE_SHIFT_EN.

Verification
REQ-031 SHALL verify reset: rst=1 mid-inc, WIDTH=8, RST_VAL=8'h5A -> do=5A, co=0 before next edge; zo=0, no=0.
REQ-032 SHALL verify load/hold: load di=80 then hold 3 cycles -> do=80, no=1, zo=0, co unchanged throughout.
REQ-033 SHALL verify inc wrap: load FF, inc -> do=00, co=1, zo=1; inc again -> do=01, co=0.
REQ-034 SHALL verify dec wrap: load 00, dec -> do=FF, co=0, no=1; dec again -> do=FE, co=1.
REQ-035 SHALL verify rotate: load 81, ci=0, rol -> do=02, co=1; ror with ci=1 -> do=81, co=0.
REQ-036 SHALL verify macro off: load 81, op=100 -> do=81, co unchanged.
